// File: rtl/sdram_access_arbiter.sv
// Shares the SDRAM command controller between LCD fetch (port 0), MSX CPU (port 1)
// and SPI loader (port 2), and injects periodic auto-refresh ahead of all ports.
module sdram_access_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 1300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_write,
  input  logic [62:0] req_address,
  input  logic [95:0] req_wdata,
  input  logic [11:0] req_wmask,
  output logic [2:0]  req_ack,
  output logic [2:0]  req_rdata_valid,
  output logic [31:0] req_rdata,
  output logic        sdram_valid,
  output logic        sdram_refresh,
  output logic        sdram_write,
  output logic [20:0] sdram_address,
  output logic [31:0] sdram_wdata,
  output logic [3:0]  sdram_wmask,
  input  logic        sdram_ready,
  input  logic        sdram_done,
  input  logic [31:0] sdram_rdata
);
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
  typedef enum logic [1:0] {OWN_P0, OWN_P1, OWN_P2, OWN_REF} owner_t;

  state_t        state, state_next;
  owner_t        owner, grant_owner;
  logic          grant, accept, finish;
  logic          rr_last_p2;
  logic          refresh_pending;
  logic [CW-1:0] refresh_count;
  logic          refresh_wrap;
  logic          sel_write;
  logic [AW-1:0] sel_address;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;

  assign refresh_wrap = (refresh_count == CW'(REFRESH_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, grant decision and the combinational accept strobe.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = OWN_P0;
    accept      = 1'b0;
    finish      = 1'b0;
    req_ack     = '0;
    unique case (state)
      ST_IDLE: begin
        grant = 1'b1;
        if (refresh_pending)                                    grant_owner = OWN_REF;
        else if (req_valid[0])                                  grant_owner = OWN_P0;
        else if (req_valid[1] && (!req_valid[2] || rr_last_p2)) grant_owner = OWN_P1;
        else if (req_valid[2])                                  grant_owner = OWN_P2;
        else                                                    grant = 1'b0;
        if (grant) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (sdram_ready && !reset) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
          if (owner != OWN_REF) req_ack = NP'(1) << owner;
        end
      end
      ST_WAIT: begin
        if (sdram_done) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Payload of the port being granted.
  always_comb begin
    sel_write   = 1'b0;
    sel_address = '0;
    sel_wdata   = '0;
    sel_wmask   = '0;
    case (grant_owner)
      OWN_P0: begin
        sel_write   = req_write[0];
        sel_address = req_address[0*AW +: AW];
        sel_wdata   = req_wdata[0*DW +: DW];
        sel_wmask   = req_wmask[0*MW +: MW];
      end
      OWN_P1: begin
        sel_write   = req_write[1];
        sel_address = req_address[1*AW +: AW];
        sel_wdata   = req_wdata[1*DW +: DW];
        sel_wmask   = req_wmask[1*MW +: MW];
      end
      OWN_P2: begin
        sel_write   = req_write[2];
        sel_address = req_address[2*AW +: AW];
        sel_wdata   = req_wdata[2*DW +: DW];
        sel_wmask   = req_wmask[2*MW +: MW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner           <= OWN_P0;
      rr_last_p2      <= 1'b1;
      refresh_pending <= 1'b0;
      refresh_count   <= '0;
      req_rdata_valid <= '0;
      req_rdata       <= '0;
      sdram_valid     <= 1'b0;
      sdram_refresh   <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_address   <= '0;
      sdram_wdata     <= '0;
      sdram_wmask     <= '0;
    end else begin
      req_rdata_valid <= '0;

      // Free-running interval timer; a wrap while already pending does not queue.
      if (refresh_wrap) begin
        refresh_count   <= '0;
        refresh_pending <= 1'b1;
      end else begin
        refresh_count <= refresh_count + CW'(1);
        if (accept && owner == OWN_REF) refresh_pending <= 1'b0;
      end

      if (grant) begin
        owner         <= grant_owner;
        sdram_valid   <= 1'b1;
        sdram_refresh <= (grant_owner == OWN_REF);
        sdram_write   <= sel_write;
        sdram_address <= sel_address;
        sdram_wdata   <= sel_wdata;
        sdram_wmask   <= sel_wmask;
        if (grant_owner == OWN_P1) rr_last_p2 <= 1'b0;
        if (grant_owner == OWN_P2) rr_last_p2 <= 1'b1;
      end

      if (accept) sdram_valid <= 1'b0;

      if (finish && owner != OWN_REF && !sdram_write) begin
        req_rdata       <= sdram_rdata;
        req_rdata_valid <= NP'(1) << owner;
      end
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_sdram_access_arbiter;
  localparam int unsigned RI = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_write;
  logic [62:0] req_address;
  logic [95:0] req_wdata;
  logic [11:0] req_wmask;
  logic [2:0]  req_ack, req_rdata_valid;
  logic [31:0] req_rdata;
  logic        sdram_valid, sdram_refresh, sdram_write;
  logic [20:0] sdram_address;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wmask;
  logic        sdram_ready, sdram_done;
  logic [31:0] sdram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_access_arbiter #(.REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_ack(req_ack), .req_rdata_valid(req_rdata_valid), .req_rdata(req_rdata),
    .sdram_valid(sdram_valid), .sdram_refresh(sdram_refresh), .sdram_write(sdram_write),
    .sdram_address(sdram_address), .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
    .sdram_ready(sdram_ready), .sdram_done(sdram_done), .sdram_rdata(sdram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0; req_wmask = '0;
    sdram_ready = 1'b0; sdram_done = 1'b0; sdram_rdata = '0;
  endtask

  task automatic set_port(input int i, input logic w, input logic [20:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    req_write[i]        = w;
    req_address[21*i +: 21] = a;
    req_wdata[32*i +: 32]   = d;
    req_wmask[4*i +: 4]     = m;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] obs;
    clear_inputs();
    set_port(0, 1'b0, 21'h0AAAA, 32'h0, 4'h0);
    set_port(1, 1'b1, 21'h0BBBB, 32'h1, 4'h1);
    set_port(2, 1'b0, 21'h0CCCC, 32'h2, 4'h2);
    req_valid = 3'b111; sdram_ready = 1'b1; sdram_done = 1'b1;
    reset = 1'b1;
    repeat (5) tick();
    obs = {req_ack, req_rdata_valid, req_rdata, sdram_valid, sdram_refresh, sdram_write,
           sdram_address, sdram_wdata, sdram_wmask};
    n_cmp++; if (obs !== 98'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    reset = 1'b0;
    tick();
    n_cmp++; if (sdram_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_valid: got %b want 1", sdram_valid); end
    n_cmp++; if (sdram_address !== 21'h0AAAA) begin n_bad++; $display("FAIL reset_first_addr: got %h want 0aaaa", sdram_address); end
    @(negedge clk);
    n_cmp++; if (req_ack !== 3'b001) begin n_bad++; $display("FAIL reset_first_ack: got %b want 001", req_ack); end
    tick();
  endtask

  task automatic test_single_read();
    clear_inputs();
    do_reset(2);
    set_port(1, 1'b0, 21'h12345, 32'h0, 4'h0);
    req_valid = 3'b010;
    tick();
    n_cmp++; if (sdram_valid !== 1'b1) begin n_bad++; $display("FAIL read_valid: got %b want 1", sdram_valid); end
    n_cmp++; if ({sdram_write, sdram_refresh, sdram_address} !== {2'b00, 21'h12345}) begin
      n_bad++; $display("FAIL read_cmd: got w=%b r=%b a=%h want 0 0 12345", sdram_write, sdram_refresh, sdram_address); end
    tick();
    n_cmp++; if (sdram_valid !== 1'b1) begin n_bad++; $display("FAIL read_valid_hold: got %b want 1", sdram_valid); end
    sdram_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ack !== 3'b010) begin n_bad++; $display("FAIL read_ack: got %b want 010", req_ack); end
    tick();
    sdram_ready = 1'b0; req_valid = 3'b000;
    n_cmp++; if (sdram_valid !== 1'b0) begin n_bad++; $display("FAIL read_valid_drop: got %b want 0", sdram_valid); end
    tick(); tick();
    sdram_done = 1'b1; sdram_rdata = 32'hDEADBEEF;
    tick();
    sdram_done = 1'b0; sdram_rdata = '0;
    n_cmp++; if ({req_rdata_valid, req_rdata} !== {3'b010, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL read_data: got %b/%h want 010/deadbeef", req_rdata_valid, req_rdata); end
    tick();
    n_cmp++; if (req_rdata_valid !== 3'b000) begin n_bad++; $display("FAIL read_pulse: got %b want 000", req_rdata_valid); end
  endtask

  task automatic test_arbitration();
    logic [2:0] got[$];
    logic [2:0] want;
    clear_inputs();
    set_port(0, 1'b0, 21'h00100, 32'h0, 4'h0);
    set_port(1, 1'b0, 21'h00111, 32'h0, 4'h0);
    set_port(2, 1'b0, 21'h00122, 32'h0, 4'h0);
    req_valid = 3'b111; sdram_ready = 1'b1; sdram_done = 1'b1;
    do_reset(2);
    for (int c = 0; c < 200 && got.size() < 6; c++) begin
      @(negedge clk);
      if (req_ack != 3'b000) got.push_back(req_ack);
      tick();
    end
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL arb_p0_count: got %0d want 6", got.size()); end
    foreach (got[k]) begin
      n_cmp++; if (got[k] !== 3'b001) begin n_bad++; $display("FAIL arb_p0_grant%0d: got %b want 001", k, got[k]); end
    end
    got.delete();
    req_valid = 3'b110;
    for (int c = 0; c < 200 && got.size() < 6; c++) begin
      @(negedge clk);
      if (req_ack != 3'b000) got.push_back(req_ack);
      tick();
    end
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL arb_rr_count: got %0d want 6", got.size()); end
    foreach (got[k]) begin
      want = (k % 2 == 0) ? 3'b010 : 3'b100;
      n_cmp++; if (got[k] !== want) begin n_bad++; $display("FAIL arb_rr_grant%0d: got %b want %b", k, got[k], want); end
    end
  endtask

  task automatic test_write();
    clear_inputs();
    do_reset(2);
    set_port(2, 1'b1, 21'h1FFFFF, 32'h11223344, 4'b0101);
    req_valid = 3'b100;
    tick();
    n_cmp++; if ({sdram_valid, sdram_refresh, sdram_write} !== 3'b101) begin
      n_bad++; $display("FAIL write_flags: got v=%b r=%b w=%b want 1 0 1", sdram_valid, sdram_refresh, sdram_write); end
    n_cmp++; if ({sdram_address, sdram_wdata, sdram_wmask} !== {21'h1FFFFF, 32'h11223344, 4'b0101}) begin
      n_bad++; $display("FAIL write_fields: got %h %h %b want 1fffff 11223344 0101", sdram_address, sdram_wdata, sdram_wmask); end
    sdram_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ack !== 3'b100) begin n_bad++; $display("FAIL write_ack: got %b want 100", req_ack); end
    tick();
    sdram_ready = 1'b0; req_valid = 3'b000;
    sdram_done = 1'b1; sdram_rdata = 32'h55AA55AA;
    tick();
    sdram_done = 1'b0;
    n_cmp++; if (req_rdata_valid !== 3'b000) begin n_bad++; $display("FAIL write_no_rdv: got %b want 000", req_rdata_valid); end
    tick();
    n_cmp++; if ({req_rdata_valid, req_rdata} !== 35'h0) begin
      n_bad++; $display("FAIL write_rdata_quiet: got %b/%h want 000/0", req_rdata_valid, req_rdata); end
  endtask

  task automatic test_refresh_idle();
    int rec[$];
    int bad_ack;
    bad_ack = 0;
    clear_inputs();
    sdram_ready = 1'b1; sdram_done = 1'b1;
    do_reset(2);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (req_ack != 3'b000) bad_ack++;
      tick();
      if (sdram_valid && sdram_refresh) rec.push_back(c);
    end
    n_cmp++; if (bad_ack != 0) begin n_bad++; $display("FAIL refresh_no_ack: got %0d acks want 0", bad_ack); end
    n_cmp++; if (rec.size() != 4) begin n_bad++; $display("FAIL refresh_count: got %0d want 4", rec.size()); end
    foreach (rec[k]) begin
      n_cmp++; if (rec[k] != 17 + 16*k) begin n_bad++; $display("FAIL refresh_cycle%0d: got %0d want %0d", k, rec[k], 17 + 16*k); end
    end
  endtask

  task automatic test_refresh_priority();
    int first_ref;
    first_ref = 0;
    clear_inputs();
    set_port(0, 1'b0, 21'h0F0F0, 32'h0, 4'h0);
    req_valid = 3'b001; sdram_ready = 1'b1; sdram_done = 1'b1;
    do_reset(2);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 20) begin
        n_cmp++; if (req_ack !== 3'b000) begin n_bad++; $display("FAIL refprio_ack: got %b want 000", req_ack); end
      end
      tick();
      if (sdram_valid && sdram_refresh && first_ref == 0) first_ref = c;
      if (c == 22) begin
        n_cmp++; if ({sdram_valid, sdram_refresh, sdram_address} !== {2'b10, 21'h0F0F0}) begin
          n_bad++; $display("FAIL refprio_p0_after: got v=%b r=%b a=%h want 1 0 0f0f0", sdram_valid, sdram_refresh, sdram_address); end
      end
    end
    n_cmp++; if (first_ref != 19) begin n_bad++; $display("FAIL refprio_cycle: got %0d want 19", first_ref); end
  endtask

  task automatic test_refresh_stall();
    int n_acc;
    n_acc = 0;
    clear_inputs();
    sdram_done = 1'b1;
    do_reset(2);
    for (int c = 1; c <= 63; c++) begin
      sdram_ready = (c >= 58);
      @(negedge clk);
      if (sdram_valid && sdram_ready && sdram_refresh) n_acc++;
      tick();
      if (c == 40) begin
        n_cmp++; if ({sdram_valid, sdram_refresh} !== 2'b11) begin
          n_bad++; $display("FAIL stall_held: got v=%b r=%b want 1 1", sdram_valid, sdram_refresh); end
      end
    end
    n_cmp++; if (n_acc != 1) begin n_bad++; $display("FAIL stall_single_refresh: got %0d want 1", n_acc); end
    n_cmp++; if (sdram_valid !== 1'b0) begin n_bad++; $display("FAIL stall_idle_after: got %b want 0", sdram_valid); end
  endtask

  task automatic test_reset_mid_wait();
    logic [97:0] obs;
    clear_inputs();
    do_reset(2);
    set_port(1, 1'b0, 21'h0ABCD, 32'h0, 4'h0);
    req_valid = 3'b010;
    tick();
    sdram_ready = 1'b1;
    tick();
    sdram_ready = 1'b0; req_valid = 3'b000; reset = 1'b1;
    tick();
    obs = {req_ack, req_rdata_valid, req_rdata, sdram_valid, sdram_refresh, sdram_write,
           sdram_address, sdram_wdata, sdram_wmask};
    n_cmp++; if (obs !== 98'h0) begin n_bad++; $display("FAIL midwait_reset: got %h want 0", obs); end
    reset = 1'b0; sdram_done = 1'b1; sdram_rdata = 32'hCAFEF00D;
    tick();
    sdram_done = 1'b0;
    n_cmp++; if ({req_rdata_valid, req_rdata} !== 35'h0) begin
      n_bad++; $display("FAIL midwait_stray_done: got %b/%h want 000/0", req_rdata_valid, req_rdata); end
    tick();
    n_cmp++; if (sdram_valid !== 1'b0) begin n_bad++; $display("FAIL midwait_no_cmd: got %b want 0", sdram_valid); end
  endtask

  // Random traffic: phase 0 = no command, 1 = offered to controller, 2 = in flight.
  task automatic test_random();
    int          ph, m_own, own;
    logic        m_pend, m_last2, ref_acc;
    int unsigned t;
    logic [2:0]  last_ack, exp_ack, exp_rv;
    logic        exp_valid, exp_ref, exp_write;
    logic [20:0] exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic [3:0]  exp_wmask;
    logic [94:0] obs, want;
    ph = 0; m_own = 0; m_pend = 1'b0; m_last2 = 1'b1; t = 0;
    last_ack = '0; exp_rv = '0; exp_valid = 1'b0; exp_ref = 1'b0; exp_write = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_wmask = '0; exp_rdata = '0;
    clear_inputs();
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_ack[i] || (!req_valid[i] && $urandom_range(3, 0) == 0) || (ph == 1 && m_own == i)) begin
          if (last_ack[i] && $urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
          else begin
            if (!(ph == 1 && m_own == i)) req_valid[i] = 1'b1;
            set_port(i, 1'($urandom_range(1, 0)), 21'($urandom), $urandom, 4'($urandom));
          end
        end
      end
      sdram_ready = 1'($urandom_range(1, 0));
      sdram_done  = ($urandom_range(2, 0) == 0);
      sdram_rdata = $urandom;
      @(negedge clk);
      exp_ack = (ph == 1 && sdram_ready && m_own < 3) ? 3'(1 << m_own) : 3'b000;
      n_cmp++; if (req_ack !== exp_ack) begin n_bad++; $display("FAIL rand_ack@%0d: got %b want %b", n, req_ack, exp_ack); end
      last_ack = exp_ack;
      exp_rv = '0; ref_acc = 1'b0;
      case (ph)
        0: begin
          if (m_pend) own = 3;
          else if (req_valid[0]) own = 0;
          else if (req_valid[1] && req_valid[2]) own = m_last2 ? 1 : 2;
          else if (req_valid[1]) own = 1;
          else if (req_valid[2]) own = 2;
          else own = -1;
          if (own >= 0) begin
            ph = 1; m_own = own; exp_valid = 1'b1; exp_ref = (own == 3);
            if (own == 1) m_last2 = 1'b0;
            if (own == 2) m_last2 = 1'b1;
            if (own < 3) begin
              exp_write = req_write[own];
              exp_addr  = req_address[21*own +: 21];
              exp_wdata = req_wdata[32*own +: 32];
              exp_wmask = req_wmask[4*own +: 4];
            end
          end
        end
        1: if (sdram_ready) begin
          ph = 2; exp_valid = 1'b0;
          if (m_own == 3) ref_acc = 1'b1;
        end
        default: if (sdram_done) begin
          ph = 0;
          if (m_own < 3 && !exp_write) begin
            exp_rdata = sdram_rdata;
            exp_rv    = 3'(1 << m_own);
          end
        end
      endcase
      t++;
      if (t % RI == 0) m_pend = 1'b1;
      else if (ref_acc) m_pend = 1'b0;
      tick();
      want = {exp_valid, exp_ref, exp_rv, exp_rdata,
              (exp_valid && !exp_ref) ? {exp_write, exp_addr, exp_wdata, exp_wmask} : 58'h0};
      obs  = {sdram_valid, sdram_refresh, req_rdata_valid, req_rdata,
              (exp_valid && !exp_ref) ? {sdram_write, sdram_address, sdram_wdata, sdram_wmask} : 58'h0};
      n_cmp++; if (obs !== want) begin n_bad++; $display("FAIL rand_outputs@%0d: got %h want %h", n, obs, want); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_arbitration();
    test_write();
    test_refresh_idle();
    test_refresh_priority();
    test_refresh_stall();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_access_arbiter.md
# sdram_access_arbiter

Shares the single on-board SDRAM controller among three requesters: LCD line fetch (port 0), MSX CPU bus (port 1) and SPI loader (port 2). Also schedules periodic auto-refresh. Sits between the requester blocks and the SDRAM command controller that drives O_sdram_*. Only one transaction is outstanding at a time; write data and address are latched at grant.

## Interface
- REFRESH_INTERVAL, 1300: clk cycles between refresh requests (≈15.1 µs at 85.9 MHz); legal range 8..65535.
- clk  in  1  system clock (85.9 MHz)
- reset  in  1  synchronous, active-high
- req_valid  in  3  bit i = port i requests; held until req_ack[i]
- req_write  in  3  bit i: 1 = write, 0 = read
- req_address  in  63  port i word address at [21*i+20 : 21*i]
- req_wdata  in  96  port i write data at [32*i+31 : 32*i]
- req_wmask  in  12  port i byte mask at [4*i+3 : 4*i], 1 = byte masked (not written)
- req_ack  out  3  one-hot, combinational; command of port i accepted this cycle
- req_rdata_valid  out  3  one-hot pulse; read data for port i on req_rdata
- req_rdata  out  32  registered read data
- sdram_valid  out  1  command present
- sdram_refresh  out  1  command is auto-refresh (address/data don't-care)
- sdram_write  out  1  1 = write
- sdram_address  out  21  word address
- sdram_wdata  out  32  write data
- sdram_wmask  out  4  byte mask
- sdram_ready  in  1  controller accepts command this cycle (valid & ready)
- sdram_done  in  1  one-cycle pulse, transaction complete; ≥1 cycle after accept
- sdram_rdata  in  32  read data, valid with sdram_done for reads

## Operation
- States: ST_IDLE, ST_REQ (sdram_valid high, awaiting ready), ST_WAIT (awaiting done).
- ST_IDLE: if any candidate → latch command into output registers, record owner (0,1,2 or refresh), go ST_REQ. Else stay.
- Priority: refresh_pending > port 0 > round-robin of ports 1/2.
- Round-robin: rr_last flag holds last granted of {1,2}; if both request, grant the other one. After reset rr_last = 2, so port 1 wins first. Only updated on grant to port 1 or 2.
- ST_REQ: sdram_valid = 1 with latched fields. On sdram_ready: req_ack[owner] = 1 same cycle (none for refresh), sdram_valid falls next cycle, go ST_WAIT.
- ST_WAIT: on sdram_done → ST_IDLE. If owner is a port and command was read: req_rdata <= sdram_rdata, req_rdata_valid[owner] = 1 next cycle. Writes and refresh produce no rdata_valid.
- Refresh counter: counts 0..REFRESH_INTERVAL-1, wraps; at wrap sets refresh_pending. Pending cleared when refresh command accepted (sdram_ready in ST_REQ, owner refresh). Wrap while pending already set: stays set (no queueing of a second refresh). Counter never stalls.
- Requester changing inputs while in ST_REQ/ST_WAIT has no effect (command latched). Requester must hold req_valid until ack; dropping it earlier is a protocol violation, latched command is still issued.
- Simultaneous pending wrap and grant decision in same cycle: pending seen next cycle.

## Timing
- Reset values: all outputs 0, state ST_IDLE, counter 0, refresh_pending 0, rr_last = 2, owner cleared.
- Reset during ST_REQ/ST_WAIT: abort, return to reset values next cycle; later sdram_done ignored in ST_IDLE.
- Grant latency: req_valid seen in ST_IDLE at edge N → sdram_valid high from cycle N+1.
- req_ack coincident with sdram_ready; requester drops or replaces request next edge.
- Read data: sdram_done at cycle M → req_rdata_valid/req_rdata at M+1 (1 cycle).
- Back-to-back: done at M → ST_IDLE in M+1 → next sdram_valid at M+2 (2 idle cycles minimum between commands).
- sdram_done outside ST_WAIT ignored; sdram_ready outside ST_REQ ignored.

## Test plan
- Reset: hold reset 5 cycles with all req_valid = 1 → all outputs 0; first grant port 0 one cycle after release.
- Single read: port 1 read addr 0x12345, ready 2 cycles after valid, done 3 cycles later with sdram_rdata 0xDEADBEEF → sdram_valid one cycle after req, sdram_address 0x12345, req_ack = 3'b010 with ready, req_rdata_valid = 3'b010 and req_rdata 0xDEADBEEF one cycle after done.
- Arbitration: all three request continuously, ready/done immediate → grant order 0 every time it requests; with port 0 idle, ports 1/2 alternate 1,2,1,2 starting with 1.
- Write: port 2 write addr 0x1FFFFF, wdata 0x11223344, wmask 4'b0101 → sdram_write 1, fields match exactly, no req_rdata_valid after done.
- Refresh: REFRESH_INTERVAL = 16, no requests → sdram_refresh+sdram_valid once per 16 cycles, no req_ack; with port 0 requesting constantly, refresh granted at next ST_IDLE ahead of port 0; two wraps while stalled (ready held 0 40 cycles) → exactly one refresh issued.
- Reset mid-ST_WAIT of port 1 read → outputs reset next cycle; subsequent sdram_done produces no req_rdata_valid.
